// File: rtl/msg_buf_pkg.sv
// Shared defaults and stored-word layout for the message ring buffer.
// A stored word carries the message-final flag alongside the payload.
package msg_buf_pkg;

  localparam int MSG_WIDTH_DEF = 16;
  localparam int DEPTH_DEF     = 32;

  typedef struct packed {
    logic                     last;
    logic [MSG_WIDTH_DEF-1:0] data;
  } msg_word_t;

endpackage

// File: rtl/msg_buf_ram.sv
// Message storage: one synchronous write port and one asynchronous read port.
module msg_buf_ram #(
  parameter  int DEPTH  = 32,
  parameter  int WIDTH  = 17,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/msg_ring_buffer.sv
// Message-granular ring buffer: words become visible to the reader only once
// their message is committed by in_last; a partial message can be aborted.
module msg_ring_buffer
  import msg_buf_pkg::*;
#(
  parameter  int MSG_WIDTH = MSG_WIDTH_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int AF_THRESH = DEPTH - 4,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MSG_WIDTH-1:0] in_data,
  input  logic                 in_last,
  input  logic                 in_abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MSG_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [ADDR_W:0]      level,
  output logic                 almost_full
);

  typedef logic [ADDR_W:0] ptr_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam ptr_t FULL_P  = ptr_t'(DEPTH);
  localparam ptr_t AF_P    = ptr_t'(AF_THRESH);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t commit_ptr_q, commit_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [MSG_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;

  msg_word_t wr_word, rd_word;
  ptr_t      used;
  logic      wr_en, rd_en;

  // Occupancy counts uncommitted words too, so an over-long message stalls the writer.
  assign used     = wr_ptr_q - rd_ptr_q;
  assign in_ready = (used != FULL_P);
  assign wr_en    = in_valid && in_ready && !in_abort;
  assign rd_en    = (commit_ptr_q != rd_ptr_q) && (!out_valid_q || out_ready);

  always_comb begin
    wr_word.last = in_last;
    wr_word.data = in_data;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;

    if (in_abort) begin
      wr_ptr_d = commit_ptr_q;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (in_last) commit_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (rd_en) begin
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
      out_valid_d = 1'b1;
      out_data_d  = rd_word.data;
      out_last_d  = rd_word.last;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  msg_buf_ram #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(msg_word_t))
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i (wr_word),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rd_word)
  );

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign level       = commit_ptr_q - rd_ptr_q;
  assign almost_full = (used >= AF_P);

endmodule

// File: tb/tb_msg_ring_buffer.sv
// Self-checking bench for msg_ring_buffer: a per-cycle vector table for the
// basic message, abort and abort-with-last cases, plus scoreboard-driven sequences.
module tb_msg_ring_buffer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_abort;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic [5:0]  level;
  logic        almost_full;

  msg_ring_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_abort    (in_abort),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .level       (level),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_abort;
    logic        out_ready;
    logic        exp_ov;
    logic [15:0] exp_data;
    logic        exp_last;
    logic [5:0]  exp_level;
    logic        exp_ir;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } sb_t;

  vec_t vecs[18];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic l, input logic a,
                              input logic ordy, input logic eov, input logic [15:0] ed,
                              input logic el, input logic [5:0] elev, input logic eir);
    vec_t r;
    r.in_valid = v;  r.in_data = d;   r.in_last = l;   r.in_abort = a; r.out_ready = ordy;
    r.exp_ov = eov;  r.exp_data = ed; r.exp_last = el; r.exp_level = elev; r.exp_ir = eir;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_abort = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b0;
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  // Pop one expected word and compare it with the word leaving the DUT this cycle.
  task automatic sb_compare(input string tag);
    sb_t e;
    if (sb.size() == 0) begin
      check({tag, " unexpected output"}, 32'(out_data), 32'hFFFF_FFFF);
    end else begin
      e = sb.pop_front();
      check({tag, " out_data"}, 32'(out_data), 32'(e.data));
      check({tag, " out_last"}, 32'(out_last), 32'(e.last));
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int cyc;
    cyc = 0;
    idle_inputs();
    out_ready = 1'b1;
    while (sb.size() != 0 && cyc < budget) begin
      if (out_valid) sb_compare(tag);
      step();
      cyc++;
    end
    check({tag, " drained within budget"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic write_word(input logic [15:0] d, input logic l);
    in_valid = 1'b1; in_data = d; in_last = l; in_abort = 1'b0;
    if (in_ready) sb.push_back('{data: d, last: l});
    step();
    idle_inputs();
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    out_ready = 1'b0;

    // Three-word message, abort of a partial message, and abort overriding valid+last.
    vecs[0]  = mk(1, 16'hA001, 0, 0, 1,  0, 16'h0,    0, 6'd0, 1);
    vecs[1]  = mk(1, 16'hA002, 0, 0, 1,  0, 16'h0,    0, 6'd0, 1);
    vecs[2]  = mk(1, 16'hA003, 1, 0, 1,  0, 16'h0,    0, 6'd3, 1);
    vecs[3]  = mk(0, 16'h0,    0, 0, 1,  1, 16'hA001, 0, 6'd2, 1);
    vecs[4]  = mk(0, 16'h0,    0, 0, 1,  1, 16'hA002, 0, 6'd1, 1);
    vecs[5]  = mk(0, 16'h0,    0, 0, 1,  1, 16'hA003, 1, 6'd0, 1);
    vecs[6]  = mk(0, 16'h0,    0, 0, 1,  0, 16'h0,    0, 6'd0, 1);
    vecs[7]  = mk(1, 16'hB001, 0, 0, 1,  0, 16'h0,    0, 6'd0, 1);
    vecs[8]  = mk(1, 16'hB002, 0, 0, 1,  0, 16'h0,    0, 6'd0, 1);
    vecs[9]  = mk(0, 16'h0,    0, 1, 1,  0, 16'h0,    0, 6'd0, 1);
    vecs[10] = mk(1, 16'hC001, 1, 0, 1,  0, 16'h0,    0, 6'd1, 1);
    vecs[11] = mk(0, 16'h0,    0, 0, 1,  1, 16'hC001, 1, 6'd0, 1);
    vecs[12] = mk(0, 16'h0,    0, 0, 1,  0, 16'h0,    0, 6'd0, 1);
    vecs[13] = mk(1, 16'hD001, 1, 1, 1,  0, 16'h0,    0, 6'd0, 1);
    vecs[14] = mk(0, 16'h0,    0, 0, 1,  0, 16'h0,    0, 6'd0, 1);
    vecs[15] = mk(1, 16'hE001, 1, 0, 1,  0, 16'h0,    0, 6'd1, 1);
    vecs[16] = mk(0, 16'h0,    0, 0, 1,  1, 16'hE001, 1, 6'd0, 1);
    vecs[17] = mk(0, 16'h0,    0, 0, 1,  0, 16'h0,    0, 6'd0, 1);

    do_reset();
    check("reset out_valid",   32'(out_valid),   32'd0);
    check("reset out_data",    32'(out_data),    32'd0);
    check("reset out_last",    32'(out_last),    32'd0);
    check("reset level",       32'(level),       32'd0);
    check("reset in_ready",    32'(in_ready),    32'd1);
    check("reset almost_full", 32'(almost_full), 32'd0);

    for (int i = 0; i < 18; i++) begin
      in_valid  = vecs[i].in_valid;
      in_data   = vecs[i].in_data;
      in_last   = vecs[i].in_last;
      in_abort  = vecs[i].in_abort;
      out_ready = vecs[i].out_ready;
      step();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d level", i),     32'(level),     32'(vecs[i].exp_level));
      check($sformatf("vec%0d in_ready", i),  32'(in_ready),  32'(vecs[i].exp_ir));
      if (vecs[i].exp_ov) begin
        check($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
        check($sformatf("vec%0d out_last", i), 32'(out_last), 32'(vecs[i].exp_last));
      end
    end
    idle_inputs();

    // Fill with out_ready low. The output register takes the first word, so the
    // memory holds 32 more: in_ready drops after word 33, almost_full from word 29.
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      if (k == 33) check("fill in_ready before word 33", 32'(in_ready), 32'd1);
      write_word(16'(k), 1'b1);
      if (k == 28) check("fill almost_full at 28", 32'(almost_full), 32'd0);
      if (k == 29) check("fill almost_full at 29", 32'(almost_full), 32'd1);
      if (k == 32) check("fill in_ready at 32",    32'(in_ready),    32'd1);
      if (k == 33) check("fill in_ready at 33",    32'(in_ready),    32'd0);
    end
    check("full level", 32'(level), 32'd32);
    write_word(16'h0BAD, 1'b1);
    check("full refuses word", 32'(level), 32'd32);
    check("full in_ready held", 32'(in_ready), 32'd0);
    check("full out_data held", 32'(out_data), 32'd1);
    out_ready = 1'b1;
    if (out_valid) sb_compare("pop");
    step();
    out_ready = 1'b0;
    check("pop re-raises in_ready", 32'(in_ready), 32'd1);
    check("pop next out_data", 32'(out_data), 32'd2);
    drain("fill drain", 200);
    step();
    check("fill drain out_valid", 32'(out_valid), 32'd0);
    check("fill drain level",     32'(level),     32'd0);

    // Single-word message stream against a random consumer.
    begin
      int sent, recv, cyc;
      sent = 0; recv = 0; cyc = 0;
      while (recv < 100 && cyc < 3000) begin
        in_valid  = (sent < 100);
        in_data   = 16'h1000 + 16'(sent);
        in_last   = 1'b1;
        in_abort  = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        if (in_valid && in_ready) begin
          sb.push_back('{data: in_data, last: 1'b1});
          sent++;
        end
        if (out_valid && out_ready) begin
          sb_compare($sformatf("stream%0d", recv));
          recv++;
        end
        step();
        cyc++;
      end
      idle_inputs();
      out_ready = 1'b0;
      check("stream received count", 32'(recv), 32'd100);
      check("stream scoreboard empty", 32'(sb.size()), 32'd0);
      sb.delete();
    end

    // Reset mid-message with committed words unread; rst wins over a write.
    step();
    for (int i = 0; i < 5; i++) write_word(16'h5000 + 16'(i), 1'b1);
    write_word(16'h6001, 1'b0);
    write_word(16'h6002, 1'b0);
    check("pre-reset level", 32'(level), 32'd4);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD; in_last = 1'b1; out_ready = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    out_ready = 1'b0;
    sb.delete();
    check("mid reset out_valid",   32'(out_valid),   32'd0);
    check("mid reset level",       32'(level),       32'd0);
    check("mid reset in_ready",    32'(in_ready),    32'd1);
    check("mid reset almost_full", 32'(almost_full), 32'd0);
    write_word(16'hF001, 1'b0);
    write_word(16'hF002, 1'b1);
    drain("post reset", 20);
    step();
    check("post reset idle", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
